result_deserializer: RTL and testbench

Receive-side collector for the serialized matrix-product stream emitted by the multiplier controller. The controller presents each result word as CHUNKS consecutive CHUNK_W-bit slices, each qualified by a one-cycle valid strobe. This block reassembles the slices into full words, stores WORDS words in a local result buffer, and signals frame completion. The host or bench reads the stored results through a random-access read port.

---
 rtl/result_deser_pkg.sv | 18 +
 rtl/result_deserializer_chunk_assembler.sv | 56 +++++
 rtl/result_deserializer.sv | 138 +++++++++++++
 tb/tb_result_deserializer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/result_deser_pkg.sv
// Shared types and default sizing for the result deserializer.
package result_deser_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    FULL    = 2'd2
  } state_t;

  localparam int DEF_CHUNK_W = 8;
  localparam int DEF_CHUNKS  = 3;
  localparam int DEF_WORDS   = 9;

  function automatic int word_width(input int chunk_w, input int chunks);
    return chunk_w * chunks;
  endfunction

endpackage

// File: rtl/result_deserializer_chunk_assembler.sv
// chunk_assembler: holds the first CHUNKS-1 slices of a word and presents the
// assembled word combinationally on the cycle its final slice arrives.
// Requires CHUNKS >= 2.
module chunk_assembler
  import result_deser_pkg::*;
#(
  parameter int CHUNK_W = DEF_CHUNK_W,
  parameter int CHUNKS  = DEF_CHUNKS,
  localparam int WORD_W = word_width(CHUNK_W, CHUNKS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear_i,
  input  logic               capture_i,
  input  logic [CHUNK_W-1:0] in_data_i,
  output logic               word_ready_o,
  output logic [WORD_W-1:0]  word_o
);

  localparam int IDX_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam int HELD_W = (CHUNKS - 1) * CHUNK_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHUNKS - 1);

  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [HELD_W-1:0] held_q, held_d;

  // Slice slot bookkeeping; the final slice bypasses the holding register.
  always_comb begin
    idx_d        = idx_q;
    held_d       = held_q;
    word_ready_o = capture_i && (idx_q == LAST_IDX);
    word_o       = {in_data_i, held_q};
    if (clear_i) begin
      idx_d = '0;
    end else if (capture_i) begin
      if (idx_q == LAST_IDX) begin
        idx_d = '0;
      end else begin
        held_d[idx_q*CHUNK_W +: CHUNK_W] = in_data_i;
        idx_d = idx_q + 1'b1;
      end
    end
  end

  // Slot index and held slices register.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q  <= '0;
      held_q <= '0;
    end else begin
      idx_q  <= idx_d;
      held_q <= held_d;
    end
  end

endmodule

// File: rtl/result_deserializer.sv
// result_deserializer: rebuilds serialized result words into a WORDS-entry
// buffer with a random-access read port.
// Optional build macro RESULT_DESER_SUM_EN adds a 16-bit running checksum.
module result_deserializer
  import result_deser_pkg::*;
#(
  parameter int CHUNK_W = DEF_CHUNK_W,
  parameter int CHUNKS  = DEF_CHUNKS,
  parameter int WORDS   = DEF_WORDS,
  localparam int WORD_W = word_width(CHUNK_W, CHUNKS),
  localparam int AW     = $clog2(WORDS),
  localparam int CW     = $clog2(WORDS + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               in_valid_i,
  input  logic [CHUNK_W-1:0] in_data_i,
  input  logic [AW-1:0]      rd_addr_i,
  output logic [WORD_W-1:0]  rd_data_o,
  output logic [CW-1:0]      word_cnt_o,
  output logic               busy_o,
  output logic               frame_done_o,
`ifdef RESULT_DESER_SUM_EN
  output logic [15:0]        checksum_o,
`endif
  output logic               overflow_o
);

  localparam logic [CW-1:0] LAST_WORD = CW'(WORDS - 1);

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;
  logic [WORD_W-1:0] buf_q [WORDS];
  logic              capture;
  logic              word_ready;
  logic [WORD_W-1:0] word;
`ifdef RESULT_DESER_SUM_EN
  logic [15:0]       sum_q, sum_d;
`endif

  // start outranks a coincident slice, so the slice is never captured.
  assign capture = in_valid_i && (state_q == COLLECT) && !start_i;

  chunk_assembler #(
    .CHUNK_W (CHUNK_W),
    .CHUNKS  (CHUNKS)
  ) u_asm (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (start_i),
    .capture_i    (capture),
    .in_data_i    (in_data_i),
    .word_ready_o (word_ready),
    .word_o       (word)
  );

  // Next-state, word counter and flag logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
`ifdef RESULT_DESER_SUM_EN
    sum_d   = sum_q;
`endif
    if (start_i) begin
      state_d = COLLECT;
      cnt_d   = '0;
      ovf_d   = 1'b0;
`ifdef RESULT_DESER_SUM_EN
      sum_d   = '0;
`endif
    end else begin
      case (state_q)
        IDLE: ;
        COLLECT: begin
          if (word_ready) begin
            cnt_d = cnt_q + 1'b1;
`ifdef RESULT_DESER_SUM_EN
            sum_d = sum_q + 16'(word);
`endif
            if (cnt_q == LAST_WORD) begin
              state_d = FULL;
              done_d  = 1'b1;
            end
          end
        end
        FULL: begin
          if (in_valid_i) ovf_d = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
`ifdef RESULT_DESER_SUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
`ifdef RESULT_DESER_SUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  // Result buffer; word_ready only fires in COLLECT, where cnt_q < WORDS.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < WORDS; i++) buf_q[i] <= '0;
    end else if (word_ready) begin
      buf_q[cnt_q[AW-1:0]] <= word;
    end
  end

  assign rd_data_o    = (32'(rd_addr_i) < WORDS) ? buf_q[rd_addr_i] : '0;
  assign word_cnt_o   = cnt_q;
  assign busy_o       = (state_q == COLLECT);
  assign frame_done_o = done_q;
  assign overflow_o   = ovf_q;
`ifdef RESULT_DESER_SUM_EN
  assign checksum_o   = sum_q;
`endif

endmodule

// File: tb/tb_result_deserializer.sv
// Bench for result_deserializer: directed table, hand sequences, random run
// checked against a queue-based reference model.
module tb_result_deserializer;

  localparam int CHUNK_W = 8;
  localparam int CHUNKS  = 3;
  localparam int WORDS   = 9;
  localparam int WORD_W  = CHUNK_W * CHUNKS;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start_i = 1'b0;
  logic              in_valid_i = 1'b0;
  logic [7:0]        in_data_i = '0;
  logic [3:0]        rd_addr_i = '0;
  logic [WORD_W-1:0] rd_data_o;
  logic [3:0]        word_cnt_o;
  logic              busy_o;
  logic              frame_done_o;
  logic              overflow_o;
`ifdef RESULT_DESER_SUM_EN
  logic [15:0]       checksum_o;
`endif

  int n_cmp = 0;
  int n_err = 0;

  result_deserializer dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .in_valid_i   (in_valid_i),
    .in_data_i    (in_data_i),
    .rd_addr_i    (rd_addr_i),
    .rd_data_o    (rd_data_o),
    .word_cnt_o   (word_cnt_o),
    .busy_o       (busy_o),
    .frame_done_o (frame_done_o),
`ifdef RESULT_DESER_SUM_EN
    .checksum_o   (checksum_o),
`endif
    .overflow_o   (overflow_o)
  );

  always #5 clk = ~clk;

  // Reference model: mode 0 idle, 1 collecting, 2 full.
  int              m_mode = 0;
  logic [7:0]      pend[$];
  logic [WORD_W-1:0] m_buf [WORDS];
  int              m_cnt = 0;
  bit              m_done = 0;
  bit              m_ovf = 0;
  logic [15:0]     m_sum = '0;

  task automatic model_edge(input bit r, input bit s, input bit v, input logic [7:0] d);
    logic [WORD_W-1:0] w;
    if (r) begin
      m_mode = 0; pend.delete(); m_cnt = 0; m_done = 0; m_ovf = 0; m_sum = '0;
      for (int i = 0; i < WORDS; i++) m_buf[i] = '0;
    end else if (s) begin
      m_mode = 1; pend.delete(); m_cnt = 0; m_done = 0; m_ovf = 0; m_sum = '0;
    end else begin
      m_done = 0;
      if (v && m_mode == 1) begin
        pend.push_back(d);
        if (pend.size() == CHUNKS) begin
          w = '0;
          for (int k = 0; k < CHUNKS; k++) w = w | (WORD_W'(pend[k]) << (k * CHUNK_W));
          m_buf[m_cnt] = w;
          m_sum = m_sum + w[15:0];
          m_cnt++;
          pend.delete();
          if (m_cnt == WORDS) begin
            m_mode = 2;
            m_done = 1;
          end
        end
      end else if (v && m_mode == 2) begin
        m_ovf = 1;
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit s, input bit v, input logic [7:0] d);
    logic [3:0] a;
    @(negedge clk);
    a = 4'($urandom_range(0, 15));
    rst = r; start_i = s; in_valid_i = v; in_data_i = d; rd_addr_i = a;
    @(posedge clk);
    model_edge(r, s, v, d);
    #1;
    chk("busy", 32'(busy_o), 32'(m_mode == 1));
    chk("frame_done", 32'(frame_done_o), 32'(m_done));
    chk("overflow", 32'(overflow_o), 32'(m_ovf));
    chk("word_cnt", 32'(word_cnt_o), 32'(m_cnt));
    chk("rd_data", 32'(rd_data_o), (a < WORDS) ? 32'(m_buf[a]) : 32'd0);
`ifdef RESULT_DESER_SUM_EN
    chk("checksum", 32'(checksum_o), 32'(m_sum));
`endif
  endtask

  task automatic read_chk(input string nm, input int addr, input logic [31:0] exp);
    rd_addr_i = 4'(addr);
    #1;
    chk(nm, 32'(rd_data_o), exp);
  endtask

  typedef struct {
    bit   st;
    bit   v;
    logic [7:0] d;
    bit   busy;
    bit   done;
    bit   ovf;
    int   cnt;
  } vec_t;

  vec_t tbl [8];

  initial begin
    for (int i = 0; i < WORDS; i++) m_buf[i] = '0;

    // start mid-word: the coincident slice is dropped and the word restarts.
    tbl[0] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0};
    tbl[1] = '{1'b0, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0, 0};
    tbl[2] = '{1'b0, 1'b1, 8'h22, 1'b1, 1'b0, 1'b0, 0};
    tbl[3] = '{1'b1, 1'b1, 8'h33, 1'b1, 1'b0, 1'b0, 0};
    tbl[4] = '{1'b0, 1'b1, 8'hA1, 1'b1, 1'b0, 1'b0, 0};
    tbl[5] = '{1'b0, 1'b1, 8'hA2, 1'b1, 1'b0, 1'b0, 0};
    tbl[6] = '{1'b0, 1'b1, 8'hA3, 1'b1, 1'b0, 1'b0, 1};
    tbl[7] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1};

    // Reset state
    step(1, 0, 0, 8'h00);
    step(1, 0, 0, 8'h00);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(frame_done_o), 32'd0);
    chk("rst_ovf", 32'(overflow_o), 32'd0);
    chk("rst_cnt", 32'(word_cnt_o), 32'd0);
    for (int a = 0; a < 16; a++) read_chk("rst_buf", a, 32'd0);

    // Slice in IDLE is ignored
    step(0, 0, 1, 8'h55);
    chk("idle_ovf", 32'(overflow_o), 32'd0);
    chk("idle_cnt", 32'(word_cnt_o), 32'd0);

    for (int i = 0; i < 8; i++) begin
      step(0, tbl[i].st, tbl[i].v, tbl[i].d);
      chk("tbl_busy", 32'(busy_o), 32'(tbl[i].busy));
      chk("tbl_done", 32'(frame_done_o), 32'(tbl[i].done));
      chk("tbl_ovf", 32'(overflow_o), 32'(tbl[i].ovf));
      chk("tbl_cnt", 32'(word_cnt_o), 32'(tbl[i].cnt));
    end
    read_chk("tbl_buf0", 0, 32'h00A3A2A1);

    // Back-to-back frame 0x01..0x1B
    step(0, 1, 0, 8'h00);
    for (int i = 1; i <= 27; i++) begin
      step(0, 0, 1, 8'(i));
      if (i == 26) chk("b2b_done_early", 32'(frame_done_o), 32'd0);
    end
    chk("b2b_done", 32'(frame_done_o), 32'd1);
    chk("b2b_busy", 32'(busy_o), 32'd0);
    chk("b2b_cnt", 32'(word_cnt_o), 32'd9);
    read_chk("b2b_buf0", 0, 32'h00030201);
    read_chk("b2b_buf8", 8, 32'h001B1A19);
    step(0, 0, 0, 8'h00);
    chk("b2b_done_pulse", 32'(frame_done_o), 32'd0);

    // Overflow in FULL
    step(0, 0, 1, 8'hFF);
    chk("ovf_set", 32'(overflow_o), 32'd1);
    step(0, 0, 0, 8'h00);
    chk("ovf_sticky", 32'(overflow_o), 32'd1);
    read_chk("ovf_buf8", 8, 32'h001B1A19);
    step(0, 1, 0, 8'h00);
    chk("ovf_clear", 32'(overflow_o), 32'd0);

    // Same frame with 2-cycle gaps
    for (int i = 1; i <= 27; i++) begin
      step(0, 0, 1, 8'(i));
      if (i < 27) begin
        chk("gap_no_done", 32'(frame_done_o), 32'd0);
        step(0, 0, 0, 8'h00);
        step(0, 0, 0, 8'h00);
      end
    end
    chk("gap_done", 32'(frame_done_o), 32'd1);
    read_chk("gap_buf0", 0, 32'h00030201);
    read_chk("gap_buf4", 4, 32'h000F0E0D);

    // rst after 4 slices, then a fresh frame
    step(0, 1, 0, 8'h00);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 8'(8'h40 + i));
    step(1, 0, 0, 8'h00);
    chk("rst_mid_done", 32'(frame_done_o), 32'd0);
    read_chk("rst_mid_buf0", 0, 32'd0);
    step(0, 1, 0, 8'h00);
    for (int i = 0; i < 27; i++) step(0, 0, 1, 8'(8'h50 + i));
    chk("rst_mid_final_done", 32'(frame_done_o), 32'd1);
    read_chk("rst_mid_buf0b", 0, 32'h00525150);

`ifdef RESULT_DESER_SUM_EN
    step(0, 1, 0, 8'h00);
    for (int w = 1; w <= 9; w++) begin
      step(0, 0, 1, 8'(w));
      step(0, 0, 1, 8'h00);
      step(0, 0, 1, 8'h00);
    end
    chk("sum_done", 32'(frame_done_o), 32'd1);
    chk("sum_value", 32'(checksum_o), 32'h002D);
`endif

    // Random traffic against the model
    for (int n = 0; n < 800; n++) begin
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 49) == 0),
           ($urandom_range(0, 9) < 6),
           8'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
